// File: rtl/posit_mantissa_aligner_pkg.sv
// Shared definitions for the posit add/sub mantissa aligner.
//   W_REG / W_EXP / W_MAN : default regime, exponent and fraction widths
//   W_ALN                 : aligned mantissa width {hidden, fraction, G, R, S}
//   W_DIFF                : signed scale-difference width
//   sign_t                : operand sign bit
//   posit_scale_diff()    : scale(big) - scale(small), scale = regime*2^W_EXP + exponent
package posit_mantissa_aligner_pkg;
  localparam int W_REG  = 4;
  localparam int W_EXP  = 2;
  localparam int W_MAN  = 8;
  localparam int W_ALN  = W_MAN + 4;
  localparam int W_DIFF = W_REG + W_EXP + 1;

  typedef logic sign_t;

  // Regime is signed; the exponent field is an unsigned offset within a regime.
  function automatic logic signed [W_DIFF-1:0] posit_scale_diff(
    input logic signed [W_REG-1:0] big_regime,
    input logic signed [W_REG-1:0] small_regime,
    input logic        [W_EXP-1:0] big_exponent,
    input logic        [W_EXP-1:0] small_exponent
  );
    logic signed [W_DIFF-1:0] reg_d, exp_d;
    reg_d = W_DIFF'(big_regime) - W_DIFF'(small_regime);
    exp_d = $signed(W_DIFF'(big_exponent)) - $signed(W_DIFF'(small_exponent));
    return (reg_d <<< W_EXP) + exp_d;
  endfunction
endpackage

// File: rtl/posit_mantissa_aligner_if.sv
// Operand-in / aligned-result-out bus of the mantissa aligner.
//   master : the upstream comparator / downstream adder side (drives in_*, out_ready)
//   slave  : the aligner itself
interface posit_mantissa_aligner_if #(
  parameter int W_REG = posit_mantissa_aligner_pkg::W_REG,
  parameter int W_EXP = posit_mantissa_aligner_pkg::W_EXP,
  parameter int W_MAN = posit_mantissa_aligner_pkg::W_MAN
);
  import posit_mantissa_aligner_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  sign_t                   big_sign;
  sign_t                   small_sign;
  logic signed [W_REG-1:0] big_regime;
  logic signed [W_REG-1:0] small_regime;
  logic        [W_EXP-1:0] big_exponent;
  logic        [W_EXP-1:0] small_exponent;
  logic        [W_MAN-1:0] big_mantissa;
  logic        [W_MAN-1:0] small_mantissa;
  logic                    small_zero;

  logic                    out_valid;
  logic                    out_ready;
  sign_t                   out_sign;
  logic                    out_eff_sub;
  logic signed [W_REG-1:0] out_regime;
  logic        [W_EXP-1:0] out_exponent;
  logic        [W_MAN+3:0] out_big_man;
  logic        [W_MAN+3:0] out_small_man;

  modport master (
    output in_valid, big_sign, small_sign, big_regime, small_regime,
           big_exponent, small_exponent, big_mantissa, small_mantissa,
           small_zero, out_ready,
    input  in_ready, out_valid, out_sign, out_eff_sub, out_regime,
           out_exponent, out_big_man, out_small_man
  );

  modport slave (
    input  in_valid, big_sign, small_sign, big_regime, small_regime,
           big_exponent, small_exponent, big_mantissa, small_mantissa,
           small_zero, out_ready,
    output in_ready, out_valid, out_sign, out_eff_sub, out_regime,
           out_exponent, out_big_man, out_small_man
  );
endinterface

// File: rtl/posit_mantissa_aligner_sticky_shifter.sv
// Combinational right shifter that can fold the shifted-out bits into the LSB.
//   W      : data width
//   SW     : shift-amount width (amounts >= W flush everything into lost)
//   STICKY : 1 = OR lost bits into dout[0], 0 = plain truncation
//   din -> dout = din >> shamt (with optional sticky LSB)
module posit_mantissa_aligner_sticky_shifter #(
  parameter int W      = 12,
  parameter int SW     = 7,
  parameter bit STICKY = 1'b1
) (
  input  logic [W-1:0]  din,
  input  logic [SW-1:0] shamt,
  output logic [W-1:0]  dout
);
  logic [W-1:0] shifted;
  logic [W-1:0] lost_mask;
  logic         lost;

  // Oversized shifts give shifted=0 and an all-ones mask, which is exactly
  // the saturation behaviour, so no separate range compare is needed.
  assign shifted   = din >> shamt;
  assign lost_mask = ~({W{1'b1}} << shamt);
  assign lost      = |(din & lost_mask);
  assign dout      = {shifted[W-1:1], shifted[0] | (STICKY & lost)};
endmodule

// File: rtl/posit_mantissa_aligner.sv
// Posit add/sub mantissa aligner: two-stage valid/ready pipeline.
//   stage 1 : scale difference, hidden-bit restore of the small mantissa
//   stage 2 : right-align the small mantissa, guard/round/sticky generation
// Ports: clk, rst (sync, active high), io (posit_mantissa_aligner_if.slave).
// Build option: ALIGNER_STICKY_EN folds shifted-out bits into the LSB; without
// it the small mantissa is plainly truncated.
module posit_mantissa_aligner #(
  parameter int W_REG = posit_mantissa_aligner_pkg::W_REG,
  parameter int W_EXP = posit_mantissa_aligner_pkg::W_EXP,
  parameter int W_MAN = posit_mantissa_aligner_pkg::W_MAN
) (
  input logic                     clk,
  input logic                     rst,
  posit_mantissa_aligner_if.slave io
);
  import posit_mantissa_aligner_pkg::*;

  localparam int WA = W_MAN + 4;
  localparam int WD = W_REG + W_EXP + 1;
`ifdef ALIGNER_STICKY_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  // handshake
  logic s1_valid, out_valid;
  logic s1_adv, s2_adv;

  assign s2_adv      = ~out_valid | io.out_ready;
  assign s1_adv      = ~s1_valid | s2_adv;
  assign io.in_ready = s1_adv;

  // scale difference (exponent is an unsigned in-regime offset)
  logic signed [WD-1:0] reg_d, exp_d, diff_raw;
  logic        [WD-1:0] diff_clamp;

  assign reg_d      = WD'($signed(io.big_regime)) - WD'($signed(io.small_regime));
  assign exp_d      = $signed(WD'(io.big_exponent)) - $signed(WD'(io.small_exponent));
  assign diff_raw   = (reg_d <<< W_EXP) + exp_d;
  // upstream ordering makes diff >= 0; a negative value is squashed to no shift
  assign diff_clamp = diff_raw[WD-1] ? '0 : diff_raw;

  // stage 1 registers
  sign_t                   s1_sign;
  logic                    s1_eff_sub;
  logic signed [W_REG-1:0] s1_regime;
  logic        [W_EXP-1:0] s1_exponent;
  logic        [WA-1:0]    s1_big_man;
  logic        [WA-1:0]    s1_pre_small;
  logic        [WD-1:0]    s1_diff;

  // stage 2 registers
  sign_t                   s2_sign;
  logic                    s2_eff_sub;
  logic signed [W_REG-1:0] s2_regime;
  logic        [W_EXP-1:0] s2_exponent;
  logic        [WA-1:0]    s2_big_man;
  logic        [WA-1:0]    s2_small_man;

  logic [WA-1:0] small_aligned;

  posit_mantissa_aligner_sticky_shifter #(
    .W      (WA),
    .SW     (WD),
    .STICKY (STICKY_EN)
  ) u_shift (
    .din   (s1_pre_small),
    .shamt (s1_diff),
    .dout  (small_aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_sign      <= '0;
      s1_eff_sub   <= 1'b0;
      s1_regime    <= '0;
      s1_exponent  <= '0;
      s1_big_man   <= '0;
      s1_pre_small <= '0;
      s1_diff      <= '0;
      out_valid    <= 1'b0;
      s2_sign      <= '0;
      s2_eff_sub   <= 1'b0;
      s2_regime    <= '0;
      s2_exponent  <= '0;
      s2_big_man   <= '0;
      s2_small_man <= '0;
    end else begin
      if (s1_adv) s1_valid <= io.in_valid;
      if (s1_adv && io.in_valid) begin
        s1_sign      <= io.big_sign;
        s1_eff_sub   <= io.big_sign ^ io.small_sign;
        s1_regime    <= io.big_regime;
        s1_exponent  <= io.big_exponent;
        s1_big_man   <= {1'b1, io.big_mantissa, 3'b000};
        // a zero small operand contributes nothing, hidden bit included
        s1_pre_small <= {~io.small_zero, io.small_mantissa & {W_MAN{~io.small_zero}}, 3'b000};
        s1_diff      <= diff_clamp;
      end
      if (s2_adv) out_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        s2_sign      <= s1_sign;
        s2_eff_sub   <= s1_eff_sub;
        s2_regime    <= s1_regime;
        s2_exponent  <= s1_exponent;
        s2_big_man   <= s1_big_man;
        s2_small_man <= small_aligned;
      end
    end
  end

  assign io.out_valid     = out_valid;
  assign io.out_sign      = s2_sign;
  assign io.out_eff_sub   = s2_eff_sub;
  assign io.out_regime    = s2_regime;
  assign io.out_exponent  = s2_exponent;
  assign io.out_big_man   = s2_big_man;
  assign io.out_small_man = s2_small_man;
endmodule

// File: tb/tb_posit_mantissa_aligner.sv
// Self-checking bench for posit_mantissa_aligner: directed alignment cases,
// backpressure burst, mid-stream reset and randomized traffic against an
// integer-arithmetic reference model with an in-order scoreboard.
module tb_posit_mantissa_aligner;
  import posit_mantissa_aligner_pkg::*;

`ifdef ALIGNER_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  typedef struct packed {
    logic             bs, ss;
    logic [W_REG-1:0] br, sr;
    logic [W_EXP-1:0] be, se;
    logic [W_MAN-1:0] bm, sm;
    logic             sz;
  } op_t;

  typedef struct packed {
    logic             s, eff;
    logic [W_REG-1:0] r;
    logic [W_EXP-1:0] e;
    logic [W_ALN-1:0] bm, sm;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  posit_mantissa_aligner_if bus ();
  posit_mantissa_aligner dut (.clk(clk), .rst(rst), .io(bus));

  int   total = 0;
  int   bad   = 0;
  res_t q[$];
  res_t held;
  logic hold_chk = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: scales as integers, mantissa as an integer value, shift by division.
  function automatic res_t model(input op_t o);
    res_t r;
    int   bsc, ssc, d, v, sh;
    bit   lost;
    bsc = int'($signed(o.br)) * (1 << W_EXP) + int'(o.be);
    ssc = int'($signed(o.sr)) * (1 << W_EXP) + int'(o.se);
    d   = bsc - ssc;
    assert (d >= 0) else $error("FAIL negdiff d=%0d", d);
    v = o.sz ? 0 : (1 << (W_MAN + 3)) + int'(o.sm) * 8;
    if (d >= W_ALN) begin
      sh   = 0;
      lost = (v != 0);
    end else begin
      sh   = v / (1 << d);
      lost = (v % (1 << d)) != 0;
    end
    sh    = sh | int'(STK & lost);
    r.s   = o.bs;
    r.eff = o.bs ^ o.ss;
    r.r   = o.br;
    r.e   = o.be;
    r.bm  = W_ALN'((1 << (W_MAN + 3)) + int'(o.bm) * 8);
    r.sm  = W_ALN'(sh);
    return r;
  endfunction

  function automatic op_t mk(input logic bs, ss, input int br, sr, be, se, bm, sm, input logic sz);
    op_t o;
    o.bs = bs; o.ss = ss;
    o.br = W_REG'(br); o.sr = W_REG'(sr);
    o.be = W_EXP'(be); o.se = W_EXP'(se);
    o.bm = W_MAN'(bm); o.sm = W_MAN'(sm);
    o.sz = sz;
    return o;
  endfunction

  // random ordered operand pair: swap scale fields if small outranks big
  function automatic op_t rnd_op();
    op_t  o;
    logic [W_REG-1:0] tr;
    logic [W_EXP-1:0] te;
    o = op_t'({$urandom, $urandom});
    o.sz = ($urandom_range(0, 7) == 0);
    if (int'($signed(o.br)) * (1 << W_EXP) + int'(o.be) <
        int'($signed(o.sr)) * (1 << W_EXP) + int'(o.se)) begin
      tr = o.br; o.br = o.sr; o.sr = tr;
      te = o.be; o.be = o.se; o.se = te;
    end
    return o;
  endfunction

  function automatic res_t observe();
    return {bus.out_sign, bus.out_eff_sub, bus.out_regime, bus.out_exponent,
            bus.out_big_man, bus.out_small_man};
  endfunction

  task automatic drive(input logic v, input op_t o, input logic rdy);
    bus.in_valid       = v;
    bus.big_sign       = o.bs;
    bus.small_sign     = o.ss;
    bus.big_regime     = o.br;
    bus.small_regime   = o.sr;
    bus.big_exponent   = o.be;
    bus.small_exponent = o.se;
    bus.big_mantissa   = o.bm;
    bus.small_mantissa = o.sm;
    bus.small_zero     = o.sz;
    bus.out_ready      = rdy;
  endtask

  // One clock: drive at negedge, check settled outputs, account for the
  // transfers that the coming posedge will perform.
  task automatic step(input logic v, input op_t o, input logic rdy, output logic acc);
    res_t got, e;
    @(negedge clk);
    drive(v, o, rdy);
    #1;
    got = observe();
    if (hold_chk) begin
      chk("hold_valid", bus.out_valid, 1'b1);
      chk("hold_data", got, held);
    end
    hold_chk = 1'b0;
    chk("in_ready", bus.in_ready, !(q.size() >= 2 && !rdy));
    if (bus.out_valid) begin
      if (q.size() == 0) chk("spurious", bus.out_valid, 1'b0);
      else if (rdy) begin
        e = q.pop_front();
        chk("data", got, e);
      end else begin
        held     = got;
        hold_chk = 1'b1;
      end
    end
    acc = v && bus.in_ready;
    if (acc) q.push_back(model(o));
  endtask

  // isolated transaction: accept, then out_valid two cycles later
  task automatic one(input string tag, input op_t o, input logic [W_ALN-1:0] sm_exp);
    logic acc;
    op_t  z;
    z = '0;
    step(1'b1, o, 1'b1, acc);
    chk({tag, "_acc"}, acc, 1'b1);
    step(1'b0, z, 1'b1, acc);
    chk({tag, "_lat1"}, bus.out_valid, 1'b0);
    step(1'b0, z, 1'b1, acc);
    chk({tag, "_lat2"}, bus.out_valid, 1'b1);
    chk({tag, "_sm"}, bus.out_small_man, sm_exp);
  endtask

  initial begin
    logic acc;
    int   sent;
    op_t  z;
    z = '0;
    drive(1'b0, z, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_ready", bus.in_ready, 1'b1);
    chk("rst_data", observe(), '0);

    // directed alignment cases
    one("d1", mk(0, 0, 1, 0, 0, 3, 'h5A, 'h80, 0), 12'h600);
    chk("d1_bm", bus.out_big_man, 12'hAD0);
    one("d4", mk(0, 0, 1, 0, 0, 0, 'h33, 'h01, 0), STK ? 12'h081 : 12'h080);
    one("d20", mk(0, 1, 3, -2, 0, 0, 'h00, 'h00, 0), STK ? 12'h001 : 12'h000);
    chk("d20_eff", bus.out_eff_sub, 1'b1);
    one("zero", mk(0, 1, 3, -2, 0, 0, 'h00, 'hFF, 1), 12'h000);
    one("d0", mk(1, 1, 2, 2, 1, 1, 'h11, 'hA5, 0), 12'hD28);
    chk("d0_eff", bus.out_eff_sub, 1'b0);

    // 8-item burst with a 5-cycle downstream stall mid-stream
    sent = 0;
    for (int c = 0; c < 30; c++) begin
      step(sent < 8, rnd_op(), !(c >= 3 && c < 8), acc);
      if (acc) sent++;
    end
    chk("burst_sent", sent, 8);
    chk("burst_drain", q.size(), 0);

    // reset with both stages full
    for (int c = 0; c < 4; c++) step(1'b1, rnd_op(), 1'b0, acc);
    chk("pre_rst_full", q.size(), 2);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, z, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    hold_chk = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_ready", bus.in_ready, 1'b1);
    chk("mid_rst_data", observe(), '0);
    for (int c = 0; c < 5; c++) step(1'b0, z, 1'b1, acc);

    // random traffic with random backpressure
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 3) != 0, rnd_op(), $urandom_range(0, 3) != 0, acc);
    for (int c = 0; c < 5; c++) step(1'b0, z, 1'b1, acc);
    chk("rand_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
